// File: rtl/spi_fetch_unit.sv
// SPI serial-flash instruction fetch unit.
// Issues READ + 24-bit address, returns one little-endian 32-bit word.
module spi_fetch_unit #(
  parameter int unsigned CLK_DIV  = 1,
  parameter logic [7:0]  READ_CMD = 8'h03
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [23:0] req_addr,
  input  logic        flush,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_data,
  output logic        SCK,
  output logic        SO,
  input  logic        SI,
  output logic        nCS,
  output logic        nWP,
  output logic        nHOLD
);

  typedef enum logic [2:0] {
    IDLE, SETUP, SHIFT, HOLD, RESP
  } state_t;

  localparam logic [7:0] T_VAL  = 8'(CLK_DIV);
  localparam logic [7:0] T_LAST = 8'(CLK_DIV - 1);

  state_t      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [5:0]  bit_q, bit_d;
  logic        sck_q, sck_d;
  logic        so_q, so_d;
  logic        ncs_q, ncs_d;
  logic [63:0] shreg_q, shreg_d;
  logic [31:0] rx_q, rx_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic [31:0] rsp_data_q, rsp_data_d;
  logic        unused_addr;

  assign unused_addr = ^req_addr[1:0];

  // Next-state and output logic; flush aborts any busy state.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    bit_d       = bit_q;
    sck_d       = sck_q;
    so_d        = so_q;
    ncs_d       = ncs_q;
    shreg_d     = shreg_q;
    rx_d        = rx_q;
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    req_ready   = 1'b0;
    unique case (state_q)
      IDLE: begin
        req_ready = !flush;
        if (req_valid && !flush) begin
          state_d = SETUP;
          cnt_d   = '0;
          shreg_d = {READ_CMD, req_addr[23:2],
                     2'b00, 32'h0};
        end
      end
      SETUP: begin
        ncs_d = 1'b0;
        so_d  = shreg_q[63];
        cnt_d = cnt_q + 8'd1;
        if (cnt_q == T_VAL) begin
          state_d = SHIFT;
          sck_d   = 1'b1;
          cnt_d   = '0;
          bit_d   = '0;
        end
      end
      SHIFT: begin
        cnt_d = cnt_q + 8'd1;
        if (cnt_q == T_LAST) begin
          cnt_d = '0;
          if (sck_q) begin
            sck_d = 1'b0;
            if (bit_q == 6'd63) begin
              state_d = HOLD;
              so_d    = 1'b0;
            end else begin
              bit_d   = bit_q + 6'd1;
              shreg_d = {shreg_q[62:0], 1'b0};
              so_d    = shreg_q[62];
            end
          end else begin
            sck_d = 1'b1;
            if (bit_q[5]) rx_d = {rx_q[30:0], SI};
          end
        end
      end
      HOLD: begin
        cnt_d = cnt_q + 8'd1;
        if (cnt_q == T_LAST) begin
          state_d     = RESP;
          ncs_d       = 1'b1;
          rsp_valid_d = 1'b1;
          rsp_data_d  = {rx_q[7:0], rx_q[15:8],
                         rx_q[23:16], rx_q[31:24]};
        end
      end
      RESP: begin
        if (rsp_ready) begin
          state_d     = IDLE;
          rsp_valid_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
    if (flush && state_q != IDLE) begin
      state_d     = IDLE;
      ncs_d       = 1'b1;
      sck_d       = 1'b0;
      so_d        = 1'b0;
      rsp_valid_d = 1'b0;
      shreg_d     = '0;
    end
  end

  // State register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      bit_q       <= '0;
      sck_q       <= 1'b0;
      so_q        <= 1'b0;
      ncs_q       <= 1'b1;
      shreg_q     <= '0;
      rx_q        <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bit_q       <= bit_d;
      sck_q       <= sck_d;
      so_q        <= so_d;
      ncs_q       <= ncs_d;
      shreg_q     <= shreg_d;
      rx_q        <= rx_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
    end
  end

  assign SCK       = sck_q;
  assign SO        = so_q;
  assign nCS       = ncs_q;
  assign nWP       = 1'b0;
  assign nHOLD     = 1'b1;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;

endmodule

// File: tb/tb_spi_fetch_unit.sv
// Bench for spi_fetch_unit: T=1 and T=3 instances
// sharing one serial-flash model, scoreboard of expected words.
module tb_spi_fetch_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [1:0]  req_valid, req_ready, flush;
  logic [1:0]  rsp_valid, rsp_ready;
  logic [1:0]  sck, so, ncs, nwp, nhold;
  logic [23:0] req_addr [2];
  logic [31:0] rsp_data [2];
  logic        si = 1'b0;

  spi_fetch_unit #(.CLK_DIV(1)) u_t1 (
    .clk(clk), .rst(rst),
    .req_valid(req_valid[0]), .req_ready(req_ready[0]),
    .req_addr(req_addr[0]), .flush(flush[0]),
    .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]),
    .rsp_data(rsp_data[0]),
    .SCK(sck[0]), .SO(so[0]), .SI(si), .nCS(ncs[0]),
    .nWP(nwp[0]), .nHOLD(nhold[0])
  );

  spi_fetch_unit #(.CLK_DIV(3)) u_t3 (
    .clk(clk), .rst(rst),
    .req_valid(req_valid[1]), .req_ready(req_ready[1]),
    .req_addr(req_addr[1]), .flush(flush[1]),
    .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]),
    .rsp_data(rsp_data[1]),
    .SCK(sck[1]), .SO(so[1]), .SI(si), .nCS(ncs[1]),
    .nWP(nwp[1]), .nHOLD(nhold[1])
  );

  typedef struct packed {
    logic [1:0]  g;
    logic [31:0] word;
    logic [31:0] cmd;
  } exp_t;

  exp_t sb_q[$];
  int   n_chk = 0;
  int   n_pass = 0;
  int   cyc = 0;
  int   acc_cyc = 0;

  always @(posedge clk) cyc++;

  task automatic check(string tag, logic [63:0] got,
                       logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h",
                  tag, got, exp);
  endtask

  function automatic logic [31:0] flash_word(logic [23:0] a);
    if (a == 24'h000104) return 32'h00A00513;
    return {a[15:0], ~a[15:0]} ^ 32'h5A3C_96E1;
  endfunction

  // Serial flash: latch cmd/addr on SCK rise, shift data on fall.
  wire f_sck = |sck;
  wire f_ncs = &ncs;
  wire f_so  = |so;
  int          fn = 0;
  int          fi;
  logic [31:0] fcmd = '0;
  logic [31:0] fword = '0;
  logic        fp_sck, fp_ncs;

  always @(f_sck or f_ncs) begin
    if (f_ncs === 1'b0 && fp_ncs === 1'b1) fn = 0;
    if (f_ncs === 1'b0 && f_sck === 1'b1 && fp_sck === 1'b0) begin
      if (fn < 32) fcmd = {fcmd[30:0], f_so};
      fn++;
      if (fn == 32) fword = flash_word(fcmd[23:0]);
    end
    if (f_ncs === 1'b0 && f_sck === 1'b0 && fp_sck === 1'b1
        && fn >= 32 && fn < 64) begin
      fi = fn - 32;
      si = fword[8*(fi/8) + 7 - (fi%8)];
    end
    fp_ncs = f_ncs;
    fp_sck = f_sck;
  end

  // Bus monitor: pulse count, SCK widths, nCS gaps, idle SCK.
  int   sck_viol = 0, pulses = 0, last_pulses = 0;
  int   min_gap = 1000, hi_run = 0, run = 0;
  bit   seen_low = 0;
  int   hw_min, hw_max, lw_min, lw_max;
  logic p_sck, p_ncs;

  task automatic clr_width();
    hw_min = 1000; hw_max = 0;
    lw_min = 1000; lw_max = 0;
  endtask

  always @(negedge clk) begin
    if ((ncs[0] === 1'b1 && sck[0] !== 1'b0) ||
        (ncs[1] === 1'b1 && sck[1] !== 1'b0)) sck_viol++;
    if (f_ncs === 1'b0 && p_ncs === 1'b1) begin
      if (seen_low && hi_run < min_gap) min_gap = hi_run;
      seen_low = 1;
      pulses = 0;
    end
    if (f_ncs === 1'b1 && p_ncs === 1'b0) last_pulses = pulses;
    if (f_ncs === 1'b1) hi_run++;
    else hi_run = 0;
    if (f_ncs === 1'b0) begin
      if (f_sck === 1'b1 && p_sck === 1'b0) pulses++;
      if (f_sck !== p_sck && run > 0) begin
        if (p_sck === 1'b1) begin
          if (run < hw_min) hw_min = run;
          if (run > hw_max) hw_max = run;
        end else begin
          if (run < lw_min) lw_min = run;
          if (run > lw_max) lw_max = run;
        end
        run = 1;
      end else run++;
    end else run = 0;
    p_ncs = f_ncs;
    p_sck = f_sck;
  end

  task automatic start_req(input int g, input logic [23:0] a,
                           input bit push, output bit ok);
    ok = 0;
    req_addr[g]  = a;
    req_valid[g] = 1'b1;
    for (int k = 0; k < 50; k++) begin
      if (req_ready[g] === 1'b1) begin
        ok = 1;
        break;
      end
      @(negedge clk);
    end
    if (!ok) begin
      check("req_accept", 0, 1);
      req_valid[g] = 1'b0;
      return;
    end
    acc_cyc = cyc + 1;
    if (push)
      sb_q.push_back({2'(g), flash_word({a[23:2], 2'b00}),
                      {8'h03, a[23:2], 2'b00}});
    @(negedge clk);
    req_valid[g] = 1'b0;
  endtask

  task automatic wait_rsp(input int g, output bit ok);
    ok = 0;
    for (int k = 0; k < 2000; k++) begin
      if (rsp_valid[g] === 1'b1) begin
        ok = 1;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic finish_rsp(input int g, input int stall);
    bit          ok, stable;
    exp_t        e;
    int          t;
    logic [31:0] d0;
    wait_rsp(g, ok);
    if (!ok) begin
      check("rsp_timeout", 0, 1);
      return;
    end
    t = (g == 0) ? 1 : 3;
    check("latency", 64'(cyc - acc_cyc), 64'(1 + 129 * t));
    if (sb_q.size() == 0) begin
      check("sb_empty", 0, 1);
      return;
    end
    e = sb_q.pop_front();
    check("sb_inst", e.g, 2'(g));
    check("rsp_data", rsp_data[g], e.word);
    check("cmd_addr", fcmd, e.cmd);
    if (stall > 0) begin
      d0 = rsp_data[g];
      stable = 1;
      repeat (stall) begin
        @(negedge clk);
        if (rsp_data[g] !== d0 || rsp_valid[g] !== 1'b1 ||
            req_ready[g] !== 1'b0 || ncs[g] !== 1'b1)
          stable = 0;
      end
      check("stall_stable", stable, 1);
    end
    rsp_ready[g] = 1'b1;
    @(negedge clk);
    rsp_ready[g] = 1'b0;
    check("rsp_done", rsp_valid[g], 0);
    check("ready_after", req_ready[g], 1);
    check("pulses64", last_pulses, 64);
  endtask

  task automatic wait_pulses(input int n);
    for (int k = 0; k < 500; k++) begin
      if (pulses >= n) return;
      @(negedge clk);
    end
    check("pulse_timeout", pulses, n);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok, quiet;
    rst = 1'b1;
    req_valid = '0; flush = '0; rsp_ready = '0;
    req_addr[0] = '0; req_addr[1] = '0;
    clr_width();
    repeat (3) @(negedge clk);
    check("rst_ncs", ncs, 2'b11);
    check("rst_sck", sck, 2'b00);
    check("rst_so", so, 2'b00);
    check("rst_rsp_valid", rsp_valid, 2'b00);
    check("rst_rsp_data", rsp_data[0], 32'h0);
    check("nwp", nwp, 2'b00);
    check("nhold", nhold, 2'b11);
    rst = 1'b0;
    @(negedge clk);
    check("idle_ready", req_ready, 2'b11);

    start_req(0, 24'h000104, 1, ok);
    finish_rsp(0, 0);

    start_req(0, 24'h001232, 1, ok);
    finish_rsp(0, 10);

    clr_width();
    start_req(1, 24'h000007, 1, ok);
    finish_rsp(1, 0);
    check("t3_hi_min", hw_min, 3);
    check("t3_hi_max", hw_max, 3);
    check("t3_lo_min", lw_min, 3);
    check("t3_lo_max", lw_max, 3);

    start_req(0, 24'h000400, 0, ok);
    wait_pulses(40);
    flush[0] = 1'b1;
    @(negedge clk);
    flush[0] = 1'b0;
    check("flush_ncs", ncs[0], 1);
    check("flush_sck", sck[0], 0);
    check("flush_so", so[0], 0);
    quiet = 1;
    repeat (150) begin
      @(negedge clk);
      if (rsp_valid[0] !== 1'b0 || ncs[0] !== 1'b1) quiet = 0;
    end
    check("flush_no_rsp", quiet, 1);
    start_req(0, 24'h0ABCD8, 1, ok);
    finish_rsp(0, 0);

    start_req(0, 24'h000020, 0, ok);
    wait_pulses(20);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("mid_rst_ncs", ncs[0], 1);
    check("mid_rst_sck", sck[0], 0);
    check("mid_rst_valid", rsp_valid[0], 0);
    check("mid_rst_data", rsp_data[0], 32'h0);
    @(negedge clk);

    start_req(0, 24'h000100, 0, ok);
    wait_rsp(0, ok);
    check("drop_rsp_seen", ok, 1);
    flush[0] = 1'b1;
    rsp_ready[0] = 1'b1;
    @(negedge clk);
    check("drop_valid", rsp_valid[0], 0);
    check("drop_no_ready", req_ready[0], 0);
    flush[0] = 1'b0;
    rsp_ready[0] = 1'b0;
    @(negedge clk);
    check("drop_still_low", rsp_valid[0], 0);
    check("drop_idle", req_ready[0], 1);

    flush[0] = 1'b1;
    req_valid[0] = 1'b1;
    req_addr[0] = 24'h000200;
    @(negedge clk);
    check("flush_req_ready", req_ready[0], 0);
    req_valid[0] = 1'b0;
    flush[0] = 1'b0;
    @(negedge clk);
    check("flush_req_ncs", ncs[0], 1);

    min_gap = 1000;
    seen_low = 0;
    start_req(0, 24'hFFFFFC, 1, ok);
    finish_rsp(0, 0);
    start_req(0, 24'hFFFFFF, 1, ok);
    finish_rsp(0, 0);
    start_req(0, 24'h000000, 1, ok);
    finish_rsp(0, 0);
    check("ncs_gap_ge2", min_gap >= 2, 1);
    check("sck_idle_low", sck_viol, 0);
    check("sb_drained", sb_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
